// File: rtl/pllcfg_err_logger.sv
// PLL-config error logger: detects changes of the CPU error code and queues {code, stamp} entries in a FWFT FIFO.
// Optional feature macro: PLLCFG_ERR_LOG_STAMP_EN adds the free-running stamp counter and per-entry stamp storage.
module pllcfg_err_logger #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         err_code,
    input  logic               clr,
    input  logic               log_ready,
    output logic               log_valid,
    output logic [7:0]         log_code,
    output logic [STAMP_W-1:0] log_stamp,
    output logic               sticky_err,
    output logic [7:0]         err_count,
    output logic               overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       s1_q, s2_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             sticky_q, sticky_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       code_mem_q [DEPTH];

    logic event_det;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic mem_we;

    // Two-stage register of the PIO output; an event is a change to a nonzero code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 8'd0;
            s2_q <= 8'd0;
        end else begin
            s1_q <= err_code;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        event_det   = (s1_q != s2_q) && (s1_q != 8'd0);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == FULL_CNT);
        pop         = !fifo_empty && log_ready;
        push        = event_det && (!fifo_full || pop);
        drop        = event_det && fifo_full && !pop;
        mem_we      = push && !clr;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;
        sticky_d    = sticky_q;
        overflow_d  = overflow_q;

        // Clear wins over any simultaneous event or pop.
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            err_count_d = 8'd0;
            sticky_d    = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (event_det) begin
                sticky_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= 8'd0;
            sticky_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
            sticky_q    <= sticky_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the outputs are gated by log_valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            code_mem_q[wr_ptr_q] <= s1_q;
        end
    end

`ifdef PLLCFG_ERR_LOG_STAMP_EN
    logic [STAMP_W-1:0] stamp_q;
    logic [STAMP_W-1:0] stamp_mem_q [DEPTH];

    // Stamp keeps running through clr; only reset zeroes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + STAMP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            stamp_mem_q[wr_ptr_q] <= stamp_q;
        end
    end

    assign log_stamp = log_valid ? stamp_mem_q[rd_ptr_q] : '0;
`else
    assign log_stamp = '0;
`endif

    assign log_valid  = !fifo_empty;
    assign log_code   = log_valid ? code_mem_q[rd_ptr_q] : 8'd0;
    assign sticky_err = sticky_q;
    assign err_count  = err_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pllcfg_err_logger.sv
// Directed self-checking bench for pllcfg_err_logger (DEPTH=4, STAMP_W=16).
module tb_pllcfg_err_logger;
  localparam int DEPTH   = 4;
  localparam int STAMP_W = 16;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [7:0]         err_code;
  logic               clr;
  logic               log_ready;
  logic               log_valid;
  logic [7:0]         log_code;
  logic [STAMP_W-1:0] log_stamp;
  logic               sticky_err;
  logic [7:0]         err_count;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  logic [STAMP_W-1:0] tb_stamp;
  logic [STAMP_W-1:0] det_stamp [5];
  logic [STAMP_W-1:0] det7;
  logic [STAMP_W-1:0] prev_stamp;
  logic [7:0]         exp_code;

  pllcfg_err_logger #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .err_code   (err_code),
    .clr        (clr),
    .log_ready  (log_ready),
    .log_valid  (log_valid),
    .log_code   (log_code),
    .log_stamp  (log_stamp),
    .sticky_err (sticky_err),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference time base: counts every edge out of reset
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_stamp <= '0;
    else          tb_stamp <= tb_stamp + 16'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_stamp(input logic [STAMP_W-1:0] s);
`ifdef PLLCFG_ERR_LOG_STAMP_EN
    return 32'(s);
`else
    return 32'(s) & 32'd0;
`endif
  endfunction

  task automatic hold_code(input logic [7:0] code, input int cycles);
    err_code = code;
    repeat (cycles) tick();
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; err_code = 8'd0; clr = 1'b0; log_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid",    32'(log_valid),  32'd0);
    check_eq("rst_code",     32'(log_code),   32'd0);
    check_eq("rst_stamp",    32'(log_stamp),  32'd0);
    check_eq("rst_count",    32'(err_count),  32'd0);
    check_eq("rst_sticky",   32'(sticky_err), 32'd0);
    check_eq("rst_overflow", 32'(overflow),   32'd0);
    reset_n = 1'b1;

    // idle with code 0
    repeat (20) tick();
    check_eq("idle_valid",  32'(log_valid),  32'd0);
    check_eq("idle_count",  32'(err_count),  32'd0);
    check_eq("idle_sticky", 32'(sticky_err), 32'd0);

    // single event, two-edge latency
    err_code = 8'h05;
    tick();
    check_eq("lat_e0_valid", 32'(log_valid), 32'd0);
    prev_stamp = tb_stamp;
    tick();
    check_eq("lat_e1_valid", 32'(log_valid),  32'd1);
    check_eq("lat_code",     32'(log_code),   32'h05);
    check_eq("lat_stamp",    32'(log_stamp),  exp_stamp(prev_stamp));
    check_eq("lat_count",    32'(err_count),  32'd1);
    check_eq("lat_sticky",   32'(sticky_err), 32'd1);
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    check_eq("pop1_valid", 32'(log_valid), 32'd0);
    check_eq("pop1_code",  32'(log_code),  32'd0);
    hold_code(8'h00, 3);
    check_eq("zero_not_logged", 32'(log_valid), 32'd0);
    check_eq("zero_count",      32'(err_count), 32'd1);
    clr_pulse();
    check_eq("clr_count",  32'(err_count),  32'd0);
    check_eq("clr_sticky", 32'(sticky_err), 32'd0);

    // fill past full: 5 events, 4 kept
    for (int j = 0; j < 5; j++) begin
      err_code = 8'(j + 1);
      tick();
      det_stamp[j] = tb_stamp;
      tick();
      tick();
    end
    check_eq("full_overflow", 32'(overflow),  32'd1);
    check_eq("full_count",    32'(err_count), 32'd5);
    check_eq("full_sticky",   32'(sticky_err), 32'd1);
    check_eq("full_head",     32'(log_code),  32'h01);
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", 32'(log_valid), 32'd1);
      check_eq("drain_code",  32'(log_code),  32'(i + 1));
      check_eq("drain_stamp", 32'(log_stamp), exp_stamp(det_stamp[i]));
      tick();
    end
    check_eq("drain_empty", 32'(log_valid), 32'd0);
    repeat (3) tick();
    check_eq("empty_ready_valid", 32'(log_valid), 32'd0);
    log_ready = 1'b0;
    hold_code(8'h00, 2);
    clr_pulse();
    check_eq("clr_overflow", 32'(overflow), 32'd0);

    // full FIFO, event and pop in the same cycle
    for (int j = 0; j < 4; j++) begin
      err_code = 8'(j + 1);
      tick();
      det_stamp[j] = tb_stamp;
      tick();
      tick();
    end
    check_eq("fill4_count",    32'(err_count), 32'd4);
    check_eq("fill4_overflow", 32'(overflow),  32'd0);
    err_code = 8'h07;
    tick();
    det7 = tb_stamp;
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    check_eq("swap_count",    32'(err_count), 32'd5);
    check_eq("swap_overflow", 32'(overflow),  32'd0);
    check_eq("swap_head",     32'(log_code),  32'h02);
    det_stamp[4] = det7;
    log_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_code = (i == 3) ? 8'h07 : 8'(i + 2);
      check_eq("swap_valid", 32'(log_valid), 32'd1);
      check_eq("swap_code",  32'(log_code),  32'(exp_code));
      check_eq("swap_stamp", 32'(log_stamp), exp_stamp(det_stamp[i + 1]));
      tick();
    end
    check_eq("swap_empty", 32'(log_valid), 32'd0);
    log_ready = 1'b0;

    // clr beats a simultaneous event
    for (int j = 0; j < 5; j++) hold_code(8'(8'h0A + j), 2);
    check_eq("pre_clr_overflow", 32'(overflow), 32'd1);
    err_code = 8'h09;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_ev_valid",    32'(log_valid),  32'd0);
    check_eq("clr_ev_count",    32'(err_count),  32'd0);
    check_eq("clr_ev_sticky",   32'(sticky_err), 32'd0);
    check_eq("clr_ev_overflow", 32'(overflow),   32'd0);
    repeat (3) tick();
    check_eq("clr_ev_late_valid", 32'(log_valid), 32'd0);
    check_eq("clr_ev_late_count", 32'(err_count), 32'd0);

    // reset mid-operation, nonzero code held across release
    hold_code(8'h31, 3);
    hold_code(8'h32, 3);
    check_eq("pre_rst_valid", 32'(log_valid), 32'd1);
    err_code = 8'h06;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(log_valid), 32'd0);
    check_eq("async_rst_code",  32'(log_code),  32'd0);
    check_eq("async_rst_count", 32'(err_count), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_e0_valid", 32'(log_valid), 32'd0);
    tick();
    check_eq("post_rst_valid", 32'(log_valid), 32'd1);
    check_eq("post_rst_code",  32'(log_code),  32'h06);
    check_eq("post_rst_count", 32'(err_count), 32'd1);
    hold_code(8'h00, 2);
    clr_pulse();

    // 260 alternating events with the consumer always ready
    log_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      err_code = i[0] ? 8'h22 : 8'h11;
      tick();
      if (i == 99) check_eq("sat_mid_count", 32'(err_count), 32'd99);
      if (i >= 1) begin
        exp_code   = (i - 1) % 2 == 1 ? 8'h22 : 8'h11;
        prev_stamp = tb_stamp - 16'd1;
        check_eq("alt_valid", 32'(log_valid), 32'd1);
        check_eq("alt_code",  32'(log_code),  32'(exp_code));
        check_eq("alt_stamp", 32'(log_stamp), exp_stamp(prev_stamp));
      end
    end
    tick();
    tick();
    check_eq("sat_count",    32'(err_count),  32'd255);
    check_eq("sat_sticky",   32'(sticky_err), 32'd1);
    check_eq("sat_overflow", 32'(overflow),   32'd0);
    check_eq("sat_empty",    32'(log_valid),  32'd0);
    log_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pllcfg_err_logger.md
PLLCFG_ERR_LOGGER -- requirements
Module: pllcfg_err_logger

Interface
REQ-001 Parameter DEPTH, default 4, log FIFO entries, power of two, 2..16.
REQ-002 Parameter STAMP_W, default 16, timestamp width in bits.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 err_code  input  8  PLL-config error code from the CPU PIO output port; 0 = no error.
REQ-006 clr  input  1  synchronous clear pulse for log and status.
REQ-007 log_ready  input  1  consumer accepts the head entry.
REQ-008 log_valid  output  1  head entry present (first-word-fall-through).
REQ-009 log_code  output  8  head entry error code.
REQ-010 log_stamp  output  STAMP_W  head entry timestamp.
REQ-011 sticky_err  output  1  set on any logged nonzero code.
REQ-012 err_count  output  8  saturating count of detected error events.
REQ-013 overflow  output  1  sticky, set when an event was dropped because the FIFO was full.

Function
REQ-014 err_code SHALL be registered twice (s1, s2) with no other input filtering; event = (s1 != s2) && (s1 != 0).
REQ-015 A change on err_code before edge E0 SHALL produce log_valid=1 after edge E1 (2-edge latency) if the FIFO was empty.
REQ-016 Free-running stamp counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-017 On an event, the entry {s1, stamp value in the detection cycle} SHALL be written at the next edge.
REQ-018 Change to code 0 SHALL NOT be logged; repeated identical codes SHALL NOT be logged.
REQ-019 Pop SHALL occur at an edge where log_valid && log_ready; log_code/log_stamp SHALL be undefined-free (0) when log_valid=0.
REQ-020 FIFO full and event without pop: entry SHALL be dropped, overflow set, err_count still incremented.
REQ-021 FIFO full, event and pop in the same cycle: both SHALL be accepted, occupancy unchanged.
REQ-022 FIFO empty: log_ready SHALL be ignored; occupancy never underflows.
REQ-023 err_count SHALL increment per event and saturate at 255.
REQ-024 sticky_err SHALL set on the edge that writes or drops an event entry.
REQ-025 clr SHALL, at the next edge, flush the FIFO, zero err_count, clear sticky_err and overflow; clr SHALL have priority over a simultaneous event or pop (event discarded).
REQ-026 clr SHALL NOT reset s1/s2 or the stamp counter.
REQ-027 Pointers SHALL be log2(DEPTH) bits wrapping naturally; occupancy counter log2(DEPTH)+1 bits.

Reset
REQ-028 reset_n low SHALL asynchronously clear s1, s2, stamp counter, pointers, occupancy, err_count, sticky_err, overflow; outputs log_valid=0, log_code=0, log_stamp=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents; no event SHALL be detected in the first cycle after release unless err_code is nonzero (s2=0 compare).

Configuration
REQ-030 Macro PLLCFG_ERR_LOG_STAMP_EN defined: stamp counter and per-entry stamp storage SHALL be present per REQ-016/017.
REQ-031 Macro PLLCFG_ERR_LOG_STAMP_EN undefined: stamp counter and stamp storage SHALL be omitted, log_stamp SHALL be tied to 0; all other behaviour identical.

Verification
REQ-032 Reset release, err_code=0x00 held 20 cycles -> log_valid=0, err_count=0, sticky_err=0.
REQ-033 err_code 0x00->0x05 before edge E0, log_ready=0 -> after E1 log_valid=1, log_code=0x05, log_stamp=stamp of detection cycle, err_count=1, sticky_err=1.
REQ-034 Codes 0x01,0x02,0x03,0x04,0x05 each held 3 cycles, DEPTH=4, log_ready=0 -> 4 entries 0x01..0x04, overflow=1, err_count=5; then drain with log_ready=1 -> codes 0x01..0x04 in order, log_valid falls after 4th pop.
REQ-035 FIFO full, new code 0x07 detected with log_ready=1 same cycle -> head 0x01 popped, 0x07 written, occupancy stays 4, overflow unchanged.
REQ-036 clr asserted in the same cycle as event for 0x09 -> after edge log_valid=0, err_count=0, sticky_err=0, overflow=0; 0x09 not logged.
REQ-037 260 alternating events 0x11/0x22 with log_ready=1 -> err_count saturates at 255; with macro undefined, log_stamp=0 on every entry.
